// File: rtl/dpram_port_arbiter_if.sv
// Requester, response and dpram port-A signals between client engines and the arbiter.
// slave = arbiter view; master = clients plus the RAM's read-data return.
interface dpram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic                  req0_lock;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic                  req1_lock;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  ram_dout,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output ram_we, ram_addr, ram_din
  );

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output ram_dout,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing dpram port A between two requesters, with bounded lock bursts.
// Grant is combinational (ready = grant, no backpressure beyond losing arbitration); read data returns 1 cycle after acceptance.
module dpram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input logic                 clk,
  input logic                 rst,
  dpram_port_arbiter_if.slave bus
);
  localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                  last_gnt;
  logic                  lock_act;
  logic                  lock_own;
  logic [CW-1:0]         lock_cnt;
  logic                  rsp_pend;
  logic                  rsp_src;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_any;
  logic                  gnt_idx;
  logic                  sel_we;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [CW-1:0]         cnt_eff;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      // A lock only holds while its owner keeps presenting beats.
      if (lock_act && (lock_own ? bus.req1_valid : bus.req0_valid)) begin
        gnt0 = ~lock_own;
        gnt1 = lock_own;
      end else if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    gnt_any   = gnt0 | gnt1;
    gnt_idx   = gnt1;
    sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
    sel_lock  = gnt1 ? bus.req1_lock  : bus.req0_lock;
    sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
    // Burst length restarts whenever someone other than the lock owner wins.
    cnt_eff   = (lock_act && (lock_own == gnt_idx)) ? lock_cnt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      lock_act <= 1'b0;
      lock_own <= 1'b0;
      lock_cnt <= '0;
      rsp_pend <= 1'b0;
      rsp_src  <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      rsp_pend <= gnt_any & ~sel_we;
      if (gnt_any) begin
        rsp_src  <= gnt_idx;
        last_gnt <= gnt_idx;
        addr_q   <= sel_addr;
        din_q    <= sel_wdata;
        if (sel_lock && (cnt_eff < CNT_LAST)) begin
          lock_act <= 1'b1;
          lock_own <= gnt_idx;
          lock_cnt <= cnt_eff + CNT_ONE;
        end else begin
          lock_act <= 1'b0;
          lock_cnt <= '0;
        end
      end else begin
        lock_act <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.ram_we     = gnt_any & sel_we;
  assign bus.ram_addr   = gnt_any ? sel_addr  : addr_q;
  assign bus.ram_din    = gnt_any ? sel_wdata : din_q;
  assign bus.rsp0_valid = rsp_pend & ~rsp_src;
  assign bus.rsp1_valid = rsp_pend & rsp_src;
  assign bus.rsp0_rdata = bus.rsp0_valid ? bus.ram_dout : '0;
  assign bus.rsp1_rdata = bus.rsp1_valid ? bus.ram_dout : '0;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Randomized and directed bench for dpram_port_arbiter against a transaction-level model.
module tb_dpram_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Environment: registered read-first RAM on port A.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model: who won last, current lock owner and beats taken in its burst,
  // the response owed next cycle, and a shadow of RAM contents.
  int            m_last;
  int            m_owner;
  int            m_burst;
  bit            m_pend;
  int            m_src;
  logic [DW-1:0] m_pdata;
  logic [AW-1:0] m_laddr;
  logic [DW-1:0] m_ldin;
  logic [DW-1:0] shadow [int];
  int            gq [$];

  function automatic logic [DW-1:0] init_val(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] shadow_rd(int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic int pick(bit v0, bit v1);
    if (m_owner >= 0 && (m_owner == 0 ? v0 : v1)) return m_owner;
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = 1;
    m_owner = -1;
    m_burst = 0;
    m_pend  = 0;
    m_src   = 0;
    m_pdata = '0;
    m_laddr = '0;
    m_ldin  = '0;
  endtask

  task automatic set_req(int n, bit v, bit we, bit lk, logic [AW-1:0] a, logic [DW-1:0] d);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_lock = lk;
      bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_lock = lk;
      bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy0"}, bus.req0_ready, 0);
    chk({tag, "_rdy1"}, bus.req1_ready, 0);
    chk({tag, "_rsp0v"}, bus.rsp0_valid, 0);
    chk({tag, "_rsp1v"}, bus.rsp1_valid, 0);
    chk({tag, "_rsp0d"}, bus.rsp0_rdata, 0);
    chk({tag, "_rsp1d"}, bus.rsp1_rdata, 0);
    chk({tag, "_we"}, bus.ram_we, 0);
    chk({tag, "_addr"}, bus.ram_addr, 0);
    chk({tag, "_din"}, bus.ram_din, 0);
  endtask

  // One cycle: check outputs mid-cycle against the model, then commit the beat.
  task automatic step();
    int g, n;
    bit we_g, lk_g;
    logic [AW-1:0] a_g;
    logic [DW-1:0] d_g;
    @(negedge clk);
    g    = pick(bus.req0_valid, bus.req1_valid);
    we_g = (g == 1) ? bus.req1_we    : bus.req0_we;
    lk_g = (g == 1) ? bus.req1_lock  : bus.req0_lock;
    a_g  = (g == 1) ? bus.req1_addr  : bus.req0_addr;
    d_g  = (g == 1) ? bus.req1_wdata : bus.req0_wdata;
    chk("rdy0", bus.req0_ready, g == 0);
    chk("rdy1", bus.req1_ready, g == 1);
    chk("ram_we", bus.ram_we, (g >= 0) && we_g);
    chk("ram_addr", bus.ram_addr, (g >= 0) ? a_g : m_laddr);
    chk("ram_din", bus.ram_din, (g >= 0) ? d_g : m_ldin);
    chk("rsp0_v", bus.rsp0_valid, m_pend && m_src == 0);
    chk("rsp1_v", bus.rsp1_valid, m_pend && m_src == 1);
    chk("rsp0_d", bus.rsp0_rdata, (m_pend && m_src == 0) ? m_pdata : '0);
    chk("rsp1_d", bus.rsp1_rdata, (m_pend && m_src == 1) ? m_pdata : '0);
    gq.push_back(bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1));

    m_pend = (g >= 0) && !we_g;
    if (g >= 0) begin
      m_src = g;
      if (!we_g) m_pdata = shadow_rd(int'(a_g));
      else shadow[int'(a_g)] = d_g;
      m_last  = g;
      m_laddr = a_g;
      m_ldin  = d_g;
      n = (m_owner == g) ? m_burst + 1 : 1;
      if (lk_g && n < ML) begin
        m_owner = g;
        m_burst = n;
      end else begin
        m_owner = -1;
        m_burst = 0;
      end
    end else begin
      m_owner = -1;
      m_burst = 0;
    end
    @(posedge clk);
    #1;
  endtask

  int exp2 [6]  = '{0, 1, 0, 1, 0, 1};
  int exp4 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp5 [8]  = '{0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    model_reset();

    // 1: reset with both requesters valid, then first grants after release
    set_req(0, 1, 0, 0, 12'h010, 32'h0);
    set_req(1, 1, 0, 0, 12'h020, 32'h0);
    #2;
    chk_reset_outputs("rst0");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst1");
    rst = 1'b0;
    gq.delete();
    step();
    chk("t1_first", gq[0], 0);
    #1;
    chk("t1_rsp0v", bus.rsp0_valid, 1);
    chk("t1_rsp0d", bus.rsp0_rdata, init_val(12'h010));
    step();

    // 2: plain round-robin reads
    gq.delete();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 0, 0, AW'(12'h040 + i), 32'h0);
      set_req(1, 1, 0, 0, AW'(12'h080 + i), 32'h0);
      step();
    end
    idle();
    step();
    for (int i = 0; i < 6; i++) chk("t2_gnt", gq[i], exp2[i]);

    // 3: write then read back from req1
    set_req(1, 1, 1, 0, 12'h123, 32'hDEAD_BEEF);
    step();
    #1;
    chk("t3_wr_norsp", bus.rsp1_valid, 0);
    set_req(1, 1, 0, 0, 12'h123, 32'h0);
    step();
    #1;
    chk("t3_rsp1v", bus.rsp1_valid, 1);
    chk("t3_rsp1d", bus.rsp1_rdata, 32'hDEAD_BEEF);
    idle();
    step();

    // 4: req0 holds lock continuously against req1
    gq.delete();
    for (int i = 0; i < 10; i++) begin
      set_req(0, 1, 0, 1, AW'(12'h200 + i), 32'h0);
      set_req(1, 1, 0, 0, AW'(12'h300 + i), 32'h0);
      step();
    end
    for (int i = 0; i < 10; i++) chk("t4_gnt", gq[i], exp4[i]);

    // 5: lock owner drops valid mid-burst, then a full fresh burst
    gq.delete();
    for (int i = 0; i < 8; i++) begin
      set_req(0, (i != 2), 0, 1, AW'(12'h400 + i), 32'h0);
      set_req(1, 1, 0, 0, AW'(12'h500 + i), 32'h0);
      step();
    end
    for (int i = 0; i < 8; i++) chk("t5_gnt", gq[i], exp5[i]);
    idle();
    step();

    // Random traffic with collisions, locks and valid drops
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++)
        set_req(n, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) < 2), AW'($urandom_range(0, 31)), $urandom);
      step();
    end
    idle();
    step();

    // 6: reset half a cycle after a read is accepted
    set_req(1, 1, 0, 0, 12'h055, 32'h0);
    step();
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 1, 0, 0, 12'h011, 32'h0);
    set_req(1, 1, 0, 0, 12'h022, 32'h0);
    gq.delete();
    step();
    chk("t6_first", gq[0], 0);
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
